fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Owns the program counter and the IF/ID pipeline register for the 5-stage RV32I pipeline.
- Drives the byte address into the instruction memory and captures the returned 32-bit word, together with its PC, into IF/ID for the decode stage.
- Honours load-use stalls from the hazard unit and branch redirects/flushes from EX.
- Detects end-of-program and misaligned redirect targets, and keeps fetch/flush statistics.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 128, instruction memory size in bytes. PC is in range while PC+3 < IMEM_BYTES.
- NOP_INSTR, 32'h0000_0000, bubble encoding written into IF/ID on flush or end-of-program (the pipeline decodes all-zero as NOP).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- stall_i  input  1  load-use stall from the hazard unit. Holds PC and IF/ID.
- branch_taken_i  input  1  branch resolved taken in EX. Redirect and flush.
- branch_target_i  input  32  byte address of the branch target.
- imem_addr_o  output  32  byte address to the instruction memory, equal to pc_q (combinational).
- imem_instr_i  input  32  instruction word returned combinationally by the instruction memory.
- ifid_pc_o  output  32  PC of the instruction held in IF/ID.
- ifid_pc_plus4_o  output  32  ifid_pc_o + 4.
- ifid_instr_o  output  32  instruction held in IF/ID.
- ifid_valid_o  output  1  IF/ID holds a real instruction (0 = bubble).
- done_o  output  1  PC has run past the end of the instruction memory.
- misalign_o  output  1  sticky flag: a redirect target had bits [1:0] != 0.
- fetch_count_o  output  32  count of valid instructions captured into IF/ID.
- flush_count_o  output  16  count of taken-branch flushes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc_q=RESET_PC.
  - ifid_pc_o=0, ifid_pc_plus4_o=4, ifid_instr_o=NOP_INSTR, ifid_valid_o=0.
  - done_o=0, misalign_o=0, both counters=0.
  - Assertion mid-operation discards all state immediately. The first fetch after release is from RESET_PC.
- Fetch latency: one cycle. The word at pc_q appears on ifid_* at the next rising edge.
- Per-edge priority, highest first:
  1. branch_taken_i=1:
     - pc_q <= {branch_target_i[31:2],2'b00}.
     - IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc and pc_plus4 hold).
     - flush_count++ (saturating at 16'hFFFF).
     - If branch_target_i[1:0]!=0, misalign_o <= 1 (sticky until reset).
     - done_o <= 0 when the aligned target is in range.
     - Overrides stall_i and done_o.
  2. stall_i=1: pc_q and all IF/ID fields hold. Counters hold.
  3. Out of range (pc_q+3 >= IMEM_BYTES):
     - pc_q holds, done_o <= 1.
     - IF/ID <= bubble. imem_instr_i is ignored.
  4. Normal:
     - pc_q <= pc_q+4.
     - ifid_pc_o <= pc_q, ifid_pc_plus4_o <= pc_q+4, ifid_instr_o <= imem_instr_i, ifid_valid_o <= 1.
     - fetch_count++ (saturating at 32'hFFFF_FFFF).
- Arithmetic: all PC adds are 32-bit with wrap. The range compare is done in 33 bits so PC near 2^32 counts as out of range.
- A redirect to an out-of-range target: done_o is set on the following edge, and no fetch occurs.
- Stall while done_o=1: no effect. Only branch_taken_i or reset clears done_o.
- imem_addr_o always reflects pc_q, including during stall and done.

Test Plan:
- Reset release, no stall/branch, memory preloaded for 0x00..0x2C -> ifid_pc_o steps 0x0,0x4,...; ifid_instr_o at pc 0x0 = 32'h0140_2103; fetch_count_o=12 after 12 edges.
- stall_i high for 2 cycles at pc_q=0x1C -> imem_addr_o stays 0x1C; ifid_pc_o=0x18 held for 2 edges; fetch_count unchanged; resumes at 0x1C.
- branch_taken_i=1, target 0x3C, with stall_i=1 on the same edge -> pc_q=0x3C next edge; ifid_valid_o=0, ifid_instr_o=0; flush_count_o=1; next edge ifid_pc_o=0x3C.
- Target 0x3E -> pc_q=0x3C, misalign_o=1 and still 1 after 10 further cycles.
- Run to pc_q=0x80 with IMEM_BYTES=128 -> done_o=1, pc_q holds 0x80, ifid_valid_o=0; then branch to 0x0 -> done_o=0, fetch resumes.
- rst_n low asynchronously mid-run at pc_q=0x30 -> outputs take reset values without a clock edge; after release imem_addr_o=0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and the IF/ID register for the RV32I pipeline.
// Latency: the word addressed by pc_q lands in IF/ID on the next rising edge.
// Backpressure: stall_i freezes the PC and IF/ID; a taken branch overrides a stall and inserts a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o,
    output logic [15:0] flush_count_o
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic        r_done;
    logic        r_misalign;
    logic [31:0] r_fetch_count;
    logic [15:0] r_flush_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_pc_oor;
    logic        w_target_oor;

    // 33-bit compares so a PC near 2^32 cannot wrap back into range.
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_target     = {branch_target_i[31:2], 2'b00};
    assign w_pc_oor     = ({1'b0, r_pc} + 33'd3) >= 33'(IMEM_BYTES);
    assign w_target_oor = ({1'b0, w_target} + 33'd3) >= 33'(IMEM_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_ifid_pc       <= 32'h0000_0000;
            r_ifid_pc_plus4 <= 32'h0000_0004;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_valid    <= 1'b0;
            r_done          <= 1'b0;
            r_misalign      <= 1'b0;
            r_fetch_count   <= 32'h0000_0000;
            r_flush_count   <= 16'h0000;
        end else if (branch_taken_i) begin
            r_pc         <= w_target;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            if (r_flush_count != 16'hFFFF) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
            if (branch_target_i[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
            // An out-of-range target is caught by the range check on the next edge.
            if (!w_target_oor) begin
                r_done <= 1'b0;
            end
        end else if (stall_i) begin
            r_pc <= r_pc;
        end else if (w_pc_oor) begin
            r_done       <= 1'b1;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            r_pc            <= w_pc_plus4;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_instr    <= imem_instr_i;
            r_ifid_valid    <= 1'b1;
            if (r_fetch_count != 32'hFFFF_FFFF) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr_o     = r_pc;
    assign ifid_pc_o       = r_ifid_pc;
    assign ifid_pc_plus4_o = r_ifid_pc_plus4;
    assign ifid_instr_o    = r_ifid_instr;
    assign ifid_valid_o    = r_ifid_valid;
    assign done_o          = r_done;
    assign misalign_o      = r_misalign;
    assign fetch_count_o   = r_fetch_count;
    assign flush_count_o   = r_flush_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main run, hand sequences for reset and range corners.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        done;
    logic        misalign;
    logic [31:0] fetch_count;
    logic [15:0] flush_count;

    int n_chk;
    int n_fail;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(128),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .branch_taken_i (br),
        .branch_target_i(tgt),
        .imem_addr_o    (imem_addr),
        .imem_instr_i   (imem_instr),
        .ifid_pc_o      (ifid_pc),
        .ifid_pc_plus4_o(ifid_pc_plus4),
        .ifid_instr_o   (ifid_instr),
        .ifid_valid_o   (ifid_valid),
        .done_o         (done),
        .misalign_o     (misalign),
        .fetch_count_o  (fetch_count),
        .flush_count_o  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: the word at 0 is a real load, the rest are tagged with their address.
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return (pc == 32'h0) ? 32'h0140_2103 : (32'hA000_0000 | pc);
    endfunction

    assign imem_instr = (imem_addr < 32'd128) ? word_at(imem_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic        v;
        logic        d;
        logic        m;
        logic [31:0] f;
        logic [15:0] fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic b, input logic [31:0] t,
                                input logic [31:0] pc, input logic [31:0] ifpc,
                                input logic v, input logic d, input logic m,
                                input logic [31:0] f, input logic [15:0] fl);
        vec_t e;
        e.stall = s; e.br = b; e.tgt = t; e.pc = pc; e.ifpc = ifpc;
        e.v = v; e.d = d; e.m = m; e.f = f; e.fl = fl;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " imem_addr"}, imem_addr, 32'h0);
        chk({tag, " ifid_pc"}, ifid_pc, 32'h0);
        chk({tag, " ifid_pc_plus4"}, ifid_pc_plus4, 32'h4);
        chk({tag, " ifid_instr"}, ifid_instr, 32'h0);
        chk({tag, " ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
        chk({tag, " done"}, {31'b0, done}, 32'h0);
        chk({tag, " misalign"}, {31'b0, misalign}, 32'h0);
        chk({tag, " fetch_count"}, fetch_count, 32'h0);
        chk({tag, " flush_count"}, {16'b0, flush_count}, 32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        stall  = 1'b0;
        br     = 1'b0;
        tgt    = 32'h0;

        // Straight-line fetch, stall at 0x1C, branch+stall, misaligned branch, run to end, branch home.
        for (int k = 1; k <= 7; k++) add(0, 0, 0, 32'(4*k), 32'(4*(k-1)), 1, 0, 0, 32'(k), 0);
        add(1, 0, 0, 32'h1C, 32'h18, 1, 0, 0, 7, 0);
        add(1, 0, 0, 32'h1C, 32'h18, 1, 0, 0, 7, 0);
        for (int j = 0; j <= 4; j++) add(0, 0, 0, 32'(32'h20 + 4*j), 32'(32'h1C + 4*j), 1, 0, 0, 32'(8+j), 0);
        add(1, 1, 32'h3C, 32'h3C, 32'h2C, 0, 0, 0, 12, 1);
        add(0, 0, 0,      32'h40, 32'h3C, 1, 0, 0, 13, 1);
        add(0, 1, 32'h3E, 32'h3C, 32'h3C, 0, 0, 1, 13, 2);
        for (int j = 1; j <= 17; j++) add(0, 0, 0, 32'(32'h3C + 4*j), 32'(32'h38 + 4*j), 1, 0, 1, 32'(13+j), 2);
        add(0, 0, 0, 32'h80, 32'h7C, 0, 1, 1, 30, 2);
        add(1, 0, 0, 32'h80, 32'h7C, 0, 1, 1, 30, 2);
        add(0, 1, 0, 32'h00, 32'h7C, 0, 0, 1, 30, 3);
        for (int j = 1; j <= 12; j++) add(0, 0, 0, 32'(4*j), 32'(4*(j-1)), 1, 0, 1, 32'(30+j), 3);

        #12;
        chk_reset_state("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            stall = vecs[i].stall;
            br    = vecs[i].br;
            tgt   = vecs[i].tgt;
            step();
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].pc);
            chk($sformatf("v%0d ifid_pc", i), ifid_pc, vecs[i].ifpc);
            chk($sformatf("v%0d ifid_pc_plus4", i), ifid_pc_plus4, vecs[i].ifpc + 32'd4);
            chk($sformatf("v%0d ifid_instr", i), ifid_instr, vecs[i].v ? word_at(vecs[i].ifpc) : 32'h0);
            chk($sformatf("v%0d ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].v});
            chk($sformatf("v%0d done", i), {31'b0, done}, {31'b0, vecs[i].d});
            chk($sformatf("v%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].m});
            chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].f);
            chk($sformatf("v%0d flush_count", i), {16'b0, flush_count}, {16'b0, vecs[i].fl});
        end
        stall = 1'b0;
        br    = 1'b0;
        tgt   = 32'h0;

        // Asynchronous reset mid-cycle at pc 0x30.
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        step();
        rst_n = 1'b1;
        chk("post_reset imem_addr", imem_addr, 32'h0);
        step();
        chk("post_reset ifid_pc", ifid_pc, 32'h0);
        chk("post_reset ifid_instr", ifid_instr, 32'h0140_2103);
        chk("post_reset ifid_valid", {31'b0, ifid_valid}, 32'h1);
        chk("post_reset fetch_count", fetch_count, 32'h1);

        // Redirect beyond the memory: done rises one edge later, nothing fetched.
        br  = 1'b1;
        tgt = 32'h200;
        step();
        chk("oor_redirect pc", imem_addr, 32'h200);
        chk("oor_redirect done", {31'b0, done}, 32'h0);
        chk("oor_redirect valid", {31'b0, ifid_valid}, 32'h0);
        chk("oor_redirect flush", {16'b0, flush_count}, 32'h1);
        br = 1'b0;
        step();
        chk("oor_next done", {31'b0, done}, 32'h1);
        chk("oor_next pc", imem_addr, 32'h200);
        chk("oor_next fetch", fetch_count, 32'h1);

        // PC at the top of the address space must not wrap back into range.
        br  = 1'b1;
        tgt = 32'hFFFF_FFFC;
        step();
        br = 1'b0;
        step();
        chk("wrap pc", imem_addr, 32'hFFFF_FFFC);
        chk("wrap done", {31'b0, done}, 32'h1);
        chk("wrap fetch", fetch_count, 32'h1);

        // Branch back in range while stalled clears done.
        br    = 1'b1;
        stall = 1'b1;
        tgt   = 32'h4;
        step();
        chk("reenter pc", imem_addr, 32'h4);
        chk("reenter done", {31'b0, done}, 32'h0);
        chk("reenter flush", {16'b0, flush_count}, 32'h3);
        br    = 1'b0;
        stall = 1'b0;
        step();
        chk("reenter ifid_pc", ifid_pc, 32'h4);
        chk("reenter ifid_instr", ifid_instr, 32'hA000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
